// File: rtl/mem_stage.sv
// Memory-access stage: registers EX results for WB and runs at most one REQ/ACK data-memory access per instruction.
// Latency: 1 cycle for non-memory ops; memory ops finish 1 cycle after dm_ACK, or after MAX_WAIT+1 WAIT cycles on timeout.
// Backpressure: stall holds upstream from a memory-op accept until the ACK or timeout cycle; no backpressure from WB.
module mem_stage #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  input  logic [31:0]           mxpc_in,
  input  logic [31:0]           alu_result_in,
  input  logic [31:0]           store_data,
  input  logic                  alu_O_in,
  input  logic                  alu_S_in,
  input  logic                  alu_C_in,
  input  logic                  alu_Z_in,
  input  logic                  uc_R_DM,
  input  logic                  uc_W_DM,
  input  logic [1:0]            uc_S_MXRB_in,
  input  logic [2:0]            uc_W_RF_in,
  output logic                  stall,
  output logic                  dm_REQ,
  output logic                  dm_WE,
  output logic [ADDR_WIDTH-1:0] dm_A,
  output logic [31:0]           dm_D,
  input  logic [31:0]           dm_Q_in,
  input  logic                  dm_ACK,
  output logic                  out_valid,
  output logic [31:0]           mxpc_out,
  output logic [31:0]           dm_Q,
  output logic [31:0]           alu_result,
  output logic                  alu_O,
  output logic                  alu_S,
  output logic                  alu_C,
  output logic                  alu_Z,
  output logic [1:0]            uc_S_MXRB,
  output logic [2:0]            uc_W_RF,
  output logic                  dm_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [7:0] CNT_MAX = 8'(MAX_WAIT);

  logic [0:0]  state;
  logic [7:0]  cnt;
  logic        rd_q;      // access returns data (a write wins when both are requested)
  logic [31:0] mxpc_q;
  logic [31:0] alu_q;
  logic [3:0]  flg_q;     // {O,S,C,Z}
  logic [1:0]  mxrb_q;
  logic [2:0]  wrf_q;

  logic memop;
  logic timeout;

  assign memop   = uc_R_DM | uc_W_DM;
  assign timeout = (cnt == CNT_MAX);

  // Upstream must hold while a memory op is being accepted or is still outstanding;
  // released in the ACK/timeout cycle so the next instruction can be presented early.
  assign stall = ((state == ST_IDLE) & in_valid & memop) |
                 ((state == ST_WAIT) & ~dm_ACK & ~timeout);

  // Access FSM: latch the memory op on accept, hold the bus stable in WAIT, count toward timeout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      cnt    <= 8'd0;
      dm_REQ <= 1'b0;
      dm_WE  <= 1'b0;
      dm_A   <= '0;
      dm_D   <= 32'd0;
      rd_q   <= 1'b0;
      mxpc_q <= 32'd0;
      alu_q  <= 32'd0;
      flg_q  <= 4'd0;
      mxrb_q <= 2'd0;
      wrf_q  <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && memop) begin
            state  <= ST_WAIT;
            cnt    <= 8'd0;
            dm_REQ <= 1'b1;
            dm_WE  <= uc_W_DM;
            dm_A   <= alu_result_in[ADDR_WIDTH-1:0];
            dm_D   <= store_data;
            rd_q   <= ~uc_W_DM;
            mxpc_q <= mxpc_in;
            alu_q  <= alu_result_in;
            flg_q  <= {alu_O_in, alu_S_in, alu_C_in, alu_Z_in};
            mxrb_q <= uc_S_MXRB_in;
            wrf_q  <= uc_W_RF_in;
          end
        end
        ST_WAIT: begin
          if (dm_ACK || timeout) begin
            state  <= ST_IDLE;
            dm_REQ <= 1'b0;
            dm_WE  <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // WB output registers: pass-through for ALU ops, latched fields on ACK/timeout, RF write cleared otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid  <= 1'b0;
      mxpc_out   <= 32'd0;
      dm_Q       <= 32'd0;
      alu_result <= 32'd0;
      alu_O      <= 1'b0;
      alu_S      <= 1'b0;
      alu_C      <= 1'b0;
      alu_Z      <= 1'b0;
      uc_S_MXRB  <= 2'd0;
      uc_W_RF    <= 3'd0;
      dm_err     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      uc_W_RF   <= 3'd0;
      dm_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && !memop) begin
            out_valid  <= 1'b1;
            mxpc_out   <= mxpc_in;
            alu_result <= alu_result_in;
            {alu_O, alu_S, alu_C, alu_Z} <= {alu_O_in, alu_S_in, alu_C_in, alu_Z_in};
            uc_S_MXRB  <= uc_S_MXRB_in;
            uc_W_RF    <= uc_W_RF_in;
            dm_Q       <= 32'd0;
          end
        end
        ST_WAIT: begin
          if (dm_ACK || timeout) begin
            out_valid  <= 1'b1;
            mxpc_out   <= mxpc_q;
            alu_result <= alu_q;
            {alu_O, alu_S, alu_C, alu_Z} <= flg_q;
            uc_S_MXRB  <= mxrb_q;
            // ACK wins over a coincident timeout; a timed-out op must not write the RF
            if (dm_ACK) begin
              uc_W_RF <= wrf_q;
              dm_Q    <= rd_q ? dm_Q_in : 32'd0;
            end else begin
              dm_Q    <= 32'd0;
              dm_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
